axi_id_remap_rd_ctrl: RTL and testbench
=======================================

# axi_id_remap_rd_ctrl

Read-channel controller for the 8-entry AXI ID remap table. It accepts AR requests with wide IDs, allocates a narrow ID from the table, and forwards each AR through a one-entry output register. On the way back it restores the original ID on R beats and releases the table slot on the last beat. It also offers a flush handshake that stalls new ARs until every outstanding read has completed.

## Interface
Parameters:
- ID_WIDTH_IN, 8, slave-side (original) ID width
- ID_WIDTH_OUT, 3, master-side (remapped) ID width; at least 3
- ADDR_WIDTH, 32, AR address width
- LEN_WIDTH, 8, AR burst length width
- DATA_WIDTH, 64, R data width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- s_ar_valid_i / s_ar_ready_o  in/out  1  slave AR handshake
- s_ar_id_i  in  ID_WIDTH_IN  original ID
- s_ar_addr_i, s_ar_len_i  in  ADDR_WIDTH, LEN_WIDTH  AR payload
- m_ar_valid_o / m_ar_ready_i  out/in  1  master AR handshake
- m_ar_id_o, m_ar_addr_o, m_ar_len_o  out  ID_WIDTH_OUT, ADDR_WIDTH, LEN_WIDTH  registered AR
- m_r_valid_i / m_r_ready_o  in/out  1  master R handshake
- m_r_id_i, m_r_data_i, m_r_resp_i, m_r_last_i  in  ID_WIDTH_OUT, DATA_WIDTH, 2, 1  R beat
- s_r_valid_o / s_r_ready_i  out/in  1  slave R handshake
- s_r_id_o, s_r_data_o, s_r_resp_o, s_r_last_o  out  ID_WIDTH_IN, DATA_WIDTH, 2, 1  restored R beat
- tbl_incr_o, tbl_orig_id_o  out  1, ID_WIDTH_IN  allocate request and the ID to store
- tbl_full_i, tbl_id_i  in  1, ID_WIDTH_OUT  table full flag and next free remapped ID
- tbl_release_o, tbl_bid_o  out  1, ID_WIDTH_OUT  release request and lookup index
- tbl_orig_id_i, tbl_empty_i  in  ID_WIDTH_IN, 1  looked-up original ID and table empty flag
- flush_i  in  1  flush request, level
- flush_done_o  out  1  one-cycle pulse when the flush is complete
- outstanding_o  out  4  allocated-slot count, 0..8
- err_o  out  1  sticky protocol error

## Operation
- States: RUN (the reset state), FLUSH, DONE.
  - RUN -> FLUSH when flush_i=1.
  - FLUSH -> DONE when m_ar_valid_o=0, outstanding_o=0 and tbl_empty_i=1.
  - DONE -> RUN unconditionally. flush_done_o=1 only in DONE.
- s_ar_ready_o = (state==RUN) & ~tbl_full_i & (~m_ar_valid_o | m_ar_ready_i).
- AR accept = s_ar_valid_i & s_ar_ready_o.
  - In the same cycle, the block drives tbl_incr_o=1 and tbl_orig_id_o=s_ar_id_i.
  - The output register loads {tbl_id_i, addr, len}.
- m_ar_valid_o is set on accept. It is cleared on an m_ar_ready_i handshake when there is no accept in the same cycle. m_ar_* stays stable while m_ar_valid_o=1 and m_ar_ready_i=0.
- R path is combinational passthrough:
  - s_r_valid_o=m_r_valid_i and m_r_ready_o=s_r_ready_i.
  - tbl_bid_o=m_r_id_i and s_r_id_o=tbl_orig_id_i.
  - data, resp and last pass through unchanged.
- tbl_release_o = m_r_valid_i & s_r_ready_i & m_r_last_i.
- outstanding_o: +1 on accept, -1 on release, unchanged when both occur in the same cycle.
- err_o is set, and stays set until rst, when either:
  - a release occurs with outstanding_o==0 and no accept in that cycle (the counter saturates at 0), or
  - an accept occurs with outstanding_o==8 (the counter saturates at 8).
- Simultaneous accept and release are legal. The table guarantees that the slots differ. A release does not unblock tbl_full_i until the next cycle.
- flush_i arriving in FLUSH or DONE is ignored. If flush_i is still high in RUN after DONE, a new flush starts.

## Timing
- AR latency is 1 cycle: accept in cycle N, m_ar_valid_o=1 in cycle N+1. Throughput is 1 AR per cycle when m_ar_ready_i=1.
- R path has 0 cycles of latency and no added state.
- Minimum flush: flush_i is sampled in cycle N, FLUSH in N+1, DONE in N+2 if the block is already idle.
- Reset values:
  - state=RUN
  - m_ar_valid_o=0, m_ar_id/addr/len=0
  - outstanding_o=0, err_o=0, flush_done_o=0, s_ar_ready_o=~tbl_full_i
- Reset mid-operation drops any pending output-register AR. The table shares rst and must clear in the same cycle.

## Test plan
- Single read: AR id=0xA5 while tbl_id_i=0 -> m_ar_id_o=0 one cycle later. R id=0, last=1 -> s_r_id_o=0xA5, tbl_release_o=1, outstanding_o returns 0.
- Fill 8 ARs with m_ar_ready_i=1 -> outstanding_o=8. tbl_full_i=1 -> s_ar_ready_o=0. One release -> accept resumes in the next cycle.
- Backpressure: m_ar_ready_i=0 with one AR held -> s_ar_ready_o=0 and m_ar_* stable. m_ar_ready_i=1 with a new AR present -> back-to-back transfer.
- Same-cycle accept and last-beat release at outstanding_o=3 -> outstanding_o stays 3 and err_o=0.
- Flush with 2 outstanding -> s_ar_ready_o=0. After both last beats -> flush_done_o pulses exactly once, then the block returns to RUN.
- Last beat with outstanding_o=0 -> err_o=1 and stays 1. rst -> err_o=0 and m_ar_valid_o=0.

Source files
------------

// File: rtl/axi_id_remap_rd_ctrl.sv
// AR/R controller for the AXI ID remap table: allocates narrow IDs on AR, restores
// original IDs on R, tracks outstanding reads and offers a drain-and-ack flush.
module axi_id_remap_rd_ctrl #(
  parameter int unsigned ID_WIDTH_IN  = 8,
  parameter int unsigned ID_WIDTH_OUT = 3,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned LEN_WIDTH    = 8,
  parameter int unsigned DATA_WIDTH   = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  // slave AR
  input  logic                    s_ar_valid_i,
  output logic                    s_ar_ready_o,
  input  logic [ID_WIDTH_IN-1:0]  s_ar_id_i,
  input  logic [ADDR_WIDTH-1:0]   s_ar_addr_i,
  input  logic [LEN_WIDTH-1:0]    s_ar_len_i,
  // master AR
  output logic                    m_ar_valid_o,
  input  logic                    m_ar_ready_i,
  output logic [ID_WIDTH_OUT-1:0] m_ar_id_o,
  output logic [ADDR_WIDTH-1:0]   m_ar_addr_o,
  output logic [LEN_WIDTH-1:0]    m_ar_len_o,
  // master R
  input  logic                    m_r_valid_i,
  output logic                    m_r_ready_o,
  input  logic [ID_WIDTH_OUT-1:0] m_r_id_i,
  input  logic [DATA_WIDTH-1:0]   m_r_data_i,
  input  logic [1:0]              m_r_resp_i,
  input  logic                    m_r_last_i,
  // slave R
  output logic                    s_r_valid_o,
  input  logic                    s_r_ready_i,
  output logic [ID_WIDTH_IN-1:0]  s_r_id_o,
  output logic [DATA_WIDTH-1:0]   s_r_data_o,
  output logic [1:0]              s_r_resp_o,
  output logic                    s_r_last_o,
  // remap table
  output logic                    tbl_incr_o,
  output logic [ID_WIDTH_IN-1:0]  tbl_orig_id_o,
  input  logic                    tbl_full_i,
  input  logic [ID_WIDTH_OUT-1:0] tbl_id_i,
  output logic                    tbl_release_o,
  output logic [ID_WIDTH_OUT-1:0] tbl_bid_o,
  input  logic [ID_WIDTH_IN-1:0]  tbl_orig_id_i,
  input  logic                    tbl_empty_i,
  // flush and status
  input  logic                    flush_i,
  output logic                    flush_done_o,
  output logic [3:0]              outstanding_o,
  output logic                    err_o
);

  typedef enum logic [1:0] {StRun, StFlush, StDone} state_e;

  state_e                  state_q, state_d;
  logic                    m_ar_valid_q;
  logic [ID_WIDTH_OUT-1:0] m_ar_id_q;
  logic [ADDR_WIDTH-1:0]   m_ar_addr_q;
  logic [LEN_WIDTH-1:0]    m_ar_len_q;
  logic [3:0]              outstanding_q, outstanding_d;
  logic                    err_q, err_d;
  logic                    accept;
  logic                    rel_beat;

  assign s_ar_ready_o  = (state_q == StRun) & ~tbl_full_i & (~m_ar_valid_q | m_ar_ready_i);
  assign accept        = s_ar_valid_i & s_ar_ready_o;
  assign tbl_incr_o    = accept;
  assign tbl_orig_id_o = s_ar_id_i;

  assign m_ar_valid_o = m_ar_valid_q;
  assign m_ar_id_o    = m_ar_id_q;
  assign m_ar_addr_o  = m_ar_addr_q;
  assign m_ar_len_o   = m_ar_len_q;

  // R channel is a pure passthrough; only the ID is swapped via the table lookup
  assign s_r_valid_o   = m_r_valid_i;
  assign m_r_ready_o   = s_r_ready_i;
  assign tbl_bid_o     = m_r_id_i;
  assign s_r_id_o      = tbl_orig_id_i;
  assign s_r_data_o    = m_r_data_i;
  assign s_r_resp_o    = m_r_resp_i;
  assign s_r_last_o    = m_r_last_i;
  assign rel_beat      = m_r_valid_i & s_r_ready_i & m_r_last_i;
  assign tbl_release_o = rel_beat;

  assign outstanding_o = outstanding_q;
  assign err_o         = err_q;
  assign flush_done_o  = (state_q == StDone);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRun:   if (flush_i) state_d = StFlush;
      StFlush: if (!m_ar_valid_q && (outstanding_q == 4'd0) && tbl_empty_i) state_d = StDone;
      StDone:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Counter saturates at both ends; hitting either end is a protocol error
  always_comb begin
    outstanding_d = outstanding_q;
    err_d         = err_q;
    if (accept && (outstanding_q == 4'd8)) err_d = 1'b1;
    if (rel_beat && !accept && (outstanding_q == 4'd0)) err_d = 1'b1;
    if (accept && !rel_beat && (outstanding_q != 4'd8)) begin
      outstanding_d = outstanding_q + 4'd1;
    end else if (rel_beat && !accept && (outstanding_q != 4'd0)) begin
      outstanding_d = outstanding_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StRun;
      outstanding_q <= 4'd0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_ar_valid_q <= 1'b0;
      m_ar_id_q    <= '0;
      m_ar_addr_q  <= '0;
      m_ar_len_q   <= '0;
    end else if (accept) begin
      m_ar_valid_q <= 1'b1;
      m_ar_id_q    <= tbl_id_i;
      m_ar_addr_q  <= s_ar_addr_i;
      m_ar_len_q   <= s_ar_len_i;
    end else if (m_ar_ready_i) begin
      m_ar_valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi_id_remap_rd_ctrl.sv
// Randomized bench for axi_id_remap_rd_ctrl; a small ID table and a transaction-level
// reference model live here and predict every output each cycle.
module tb_axi_id_remap_rd_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        s_ar_valid_i, s_ar_ready_o;
  logic [7:0]  s_ar_id_i;
  logic [31:0] s_ar_addr_i;
  logic [7:0]  s_ar_len_i;
  logic        m_ar_valid_o, m_ar_ready_i;
  logic [2:0]  m_ar_id_o;
  logic [31:0] m_ar_addr_o;
  logic [7:0]  m_ar_len_o;
  logic        m_r_valid_i, m_r_ready_o;
  logic [2:0]  m_r_id_i;
  logic [63:0] m_r_data_i;
  logic [1:0]  m_r_resp_i;
  logic        m_r_last_i;
  logic        s_r_valid_o, s_r_ready_i;
  logic [7:0]  s_r_id_o;
  logic [63:0] s_r_data_o;
  logic [1:0]  s_r_resp_o;
  logic        s_r_last_o;
  logic        tbl_incr_o;
  logic [7:0]  tbl_orig_id_o;
  logic        tbl_full_i;
  logic [2:0]  tbl_id_i;
  logic        tbl_release_o;
  logic [2:0]  tbl_bid_o;
  logic [7:0]  tbl_orig_id_i;
  logic        tbl_empty_i;
  logic        flush_i, flush_done_o;
  logic [3:0]  outstanding_o;
  logic        err_o;

  axi_id_remap_rd_ctrl dut (
    .clk(clk), .rst(rst),
    .s_ar_valid_i(s_ar_valid_i), .s_ar_ready_o(s_ar_ready_o), .s_ar_id_i(s_ar_id_i),
    .s_ar_addr_i(s_ar_addr_i), .s_ar_len_i(s_ar_len_i),
    .m_ar_valid_o(m_ar_valid_o), .m_ar_ready_i(m_ar_ready_i), .m_ar_id_o(m_ar_id_o),
    .m_ar_addr_o(m_ar_addr_o), .m_ar_len_o(m_ar_len_o),
    .m_r_valid_i(m_r_valid_i), .m_r_ready_o(m_r_ready_o), .m_r_id_i(m_r_id_i),
    .m_r_data_i(m_r_data_i), .m_r_resp_i(m_r_resp_i), .m_r_last_i(m_r_last_i),
    .s_r_valid_o(s_r_valid_o), .s_r_ready_i(s_r_ready_i), .s_r_id_o(s_r_id_o),
    .s_r_data_o(s_r_data_o), .s_r_resp_o(s_r_resp_o), .s_r_last_o(s_r_last_o),
    .tbl_incr_o(tbl_incr_o), .tbl_orig_id_o(tbl_orig_id_o), .tbl_full_i(tbl_full_i),
    .tbl_id_i(tbl_id_i), .tbl_release_o(tbl_release_o), .tbl_bid_o(tbl_bid_o),
    .tbl_orig_id_i(tbl_orig_id_i), .tbl_empty_i(tbl_empty_i),
    .flush_i(flush_i), .flush_done_o(flush_done_o), .outstanding_o(outstanding_o),
    .err_o(err_o)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;

  // Environment table: which narrow IDs are in use and the wide ID each maps to
  bit         tbl_v[8];
  logic [7:0] tbl_o[8];

  // Reference model: outstanding reads, sticky error, flush phase, pending AR
  int unsigned mdl_cnt;
  bit          mdl_err;
  int          mdl_phase;  // 0 run, 1 draining, 2 acknowledge
  bit          mdl_pend;
  logic [2:0]  mdl_id;
  logic [31:0] mdl_addr;
  logic [7:0]  mdl_len;
  int unsigned done_pulses;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int tbl_used();
    int n = 0;
    for (int i = 0; i < 8; i++) if (tbl_v[i]) n++;
    return n;
  endfunction

  task automatic idle();
    s_ar_valid_i = 1'b0; s_ar_id_i = 8'($urandom); s_ar_addr_i = $urandom;
    s_ar_len_i = 8'($urandom); m_ar_ready_i = 1'b1;
    m_r_valid_i = 1'b0; m_r_id_i = 3'($urandom); m_r_data_i = {$urandom, $urandom};
    m_r_resp_i = 2'($urandom); m_r_last_i = 1'b0; s_r_ready_i = 1'b1; flush_i = 1'b0;
  endtask

  task automatic r_beat(input int slot, input bit last);
    m_r_valid_i = 1'b1; m_r_id_i = 3'(slot); m_r_last_i = last; s_r_ready_i = 1'b1;
    m_r_data_i = {$urandom, $urandom};
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin tbl_v[i] = 1'b0; tbl_o[i] = 8'h00; end
    mdl_cnt = 0; mdl_err = 0; mdl_phase = 0; mdl_pend = 0;
    mdl_id = '0; mdl_addr = '0; mdl_len = '0;
  endtask

  task automatic drive_tbl();
    int free = -1;
    for (int i = 7; i >= 0; i--) if (!tbl_v[i]) free = i;
    tbl_full_i    = (free < 0);
    tbl_id_i      = (free < 0) ? 3'd0 : 3'(free);
    tbl_empty_i   = (tbl_used() == 0);
    tbl_orig_id_i = tbl_o[m_r_id_i];
  endtask

  // One cycle: inputs already set after a falling edge; check, then advance model
  task automatic step();
    bit exp_rdy, acc, rel;
    int nphase;
    drive_tbl();
    #1;
    exp_rdy = (mdl_phase == 0) && !tbl_full_i && (!mdl_pend || m_ar_ready_i);
    acc     = s_ar_valid_i && exp_rdy;
    rel     = m_r_valid_i && s_r_ready_i && m_r_last_i;
    chk("s_ar_ready", 64'(s_ar_ready_o), 64'(exp_rdy));
    chk("tbl_incr", 64'(tbl_incr_o), 64'(acc));
    if (acc) chk("tbl_orig_id", 64'(tbl_orig_id_o), 64'(s_ar_id_i));
    chk("m_ar_valid", 64'(m_ar_valid_o), 64'(mdl_pend));
    if (mdl_pend) begin
      chk("m_ar_id", 64'(m_ar_id_o), 64'(mdl_id));
      chk("m_ar_addr", 64'(m_ar_addr_o), 64'(mdl_addr));
      chk("m_ar_len", 64'(m_ar_len_o), 64'(mdl_len));
    end
    chk("s_r_valid", 64'(s_r_valid_o), 64'(m_r_valid_i));
    chk("m_r_ready", 64'(m_r_ready_o), 64'(s_r_ready_i));
    if (m_r_valid_i) begin
      chk("s_r_id", 64'(s_r_id_o), 64'(tbl_o[m_r_id_i]));
      chk("s_r_data", s_r_data_o, m_r_data_i);
      chk("s_r_resp_last", 64'({s_r_resp_o, s_r_last_o}), 64'({m_r_resp_i, m_r_last_i}));
      chk("tbl_bid", 64'(tbl_bid_o), 64'(m_r_id_i));
    end
    chk("tbl_release", 64'(tbl_release_o), 64'(rel));
    chk("outstanding", 64'(outstanding_o), 64'(mdl_cnt));
    chk("err", 64'(err_o), 64'(mdl_err));
    chk("flush_done", 64'(flush_done_o), 64'(mdl_phase == 2));
    if (flush_done_o) done_pulses++;

    nphase = mdl_phase;
    case (mdl_phase)
      0: if (flush_i) nphase = 1;
      1: if (!mdl_pend && mdl_cnt == 0 && tbl_used() == 0) nphase = 2;
      default: nphase = 0;
    endcase
    if ((acc && mdl_cnt == 8) || (rel && !acc && mdl_cnt == 0)) mdl_err = 1;
    if (acc && !rel) mdl_cnt = (mdl_cnt < 8) ? mdl_cnt + 1 : 8;
    else if (rel && !acc) mdl_cnt = (mdl_cnt > 0) ? mdl_cnt - 1 : 0;
    if (acc) begin
      mdl_pend = 1; mdl_id = tbl_id_i; mdl_addr = s_ar_addr_i; mdl_len = s_ar_len_i;
    end else if (m_ar_ready_i) begin
      mdl_pend = 0;
    end
    mdl_phase = nphase;
    @(posedge clk);
    if (rel) tbl_v[m_r_id_i] = 1'b0;
    if (acc) begin tbl_v[tbl_id_i] = 1'b1; tbl_o[tbl_id_i] = s_ar_id_i; end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    drive_tbl();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    int slots[$];
    model_reset();
    do_reset();
    idle(); step();

    // single read
    idle(); s_ar_valid_i = 1; s_ar_id_i = 8'hA5; step();
    idle(); step();
    idle(); r_beat(0, 1); step();
    idle(); step();

    // fill to 8, one release, accept resumes
    idle(); s_ar_valid_i = 1;
    for (int i = 0; i < 10; i++) begin s_ar_id_i = 8'($urandom); step(); end
    idle(); r_beat(3, 1); step();
    idle(); s_ar_valid_i = 1; step(); step();
    for (int i = 0; i < 8; i++) begin idle(); r_beat(i, 1); step(); end

    // backpressure then back-to-back
    idle(); m_ar_ready_i = 0; s_ar_valid_i = 1;
    for (int i = 0; i < 4; i++) step();
    m_ar_ready_i = 1; step(); step();

    // same-cycle accept and release at 3
    idle(); s_ar_valid_i = 1; r_beat(0, 1); step();
    idle(); step();

    // flush with 2 outstanding
    idle(); r_beat(1, 1); step();
    done_pulses = 0;
    idle(); flush_i = 1; step();
    idle(); s_ar_valid_i = 1; step(); step(); step();
    idle(); r_beat(2, 1); step();
    idle(); r_beat(3, 0); step();
    idle(); r_beat(3, 1); step();
    idle(); for (int i = 0; i < 4; i++) step();
    chk("flush_pulses", 64'(done_pulses), 64'd1);

    // randomized traffic with a reset in the middle
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      idle();
      s_ar_valid_i = 1'($urandom_range(0, 1));
      m_ar_ready_i = ($urandom_range(0, 3) != 0);
      s_r_ready_i  = ($urandom_range(0, 3) != 0);
      flush_i      = ($urandom_range(0, 39) == 0);
      slots.delete();
      for (int i = 0; i < 8; i++) if (tbl_v[i]) slots.push_back(i);
      if (slots.size() > 0 && $urandom_range(0, 1) == 1) begin
        r_beat(slots[$urandom_range(0, slots.size() - 1)], 1'($urandom_range(0, 1)));
        s_r_ready_i = ($urandom_range(0, 3) != 0);
      end
      step();
    end

    // stray last beat with nothing outstanding, then reset clears the error
    do_reset();
    idle(); s_ar_valid_i = 1; m_ar_ready_i = 0; step();
    idle(); m_ar_ready_i = 0; r_beat(5, 1); step();
    idle(); m_ar_ready_i = 0; r_beat(6, 1); step();
    idle(); m_ar_ready_i = 0; step(); step();
    do_reset();
    idle(); step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
